gcn_input_buffer: RTL and testbench

Upstream stage of the GCN core. Accepts a host load stream holding weight columns, feature rows and the COO edge list, then issues a one-cycle start to the core. While the core runs, it serves the core's FM/WM read requests (registered, 1-cycle latency) and COO column lookups (combinational). It returns to idle when the core signals done.

---
 rtl/gcn_input_buffer.sv | 134 +++++++++++++
 tb/tb_gcn_input_buffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gcn_input_buffer.sv
// Input stage of the GCN core: takes a host stream of weight columns, feature rows and
// COO edges, then fires start and serves core reads until gcn_done.
module gcn_input_buffer #(
  parameter int WEIGHT_ROWS     = 96,
  parameter int WEIGHT_COLS     = 3,
  parameter int FEATURE_ROWS    = 6,
  parameter int WEIGHT_WIDTH    = 5,
  parameter int ADDRESS_WIDTH   = 13,
  parameter int FEATURE_BASE    = 512,
  parameter int COO_NUM_OF_COLS = 6,
  parameter int COO_BW          = $clog2(COO_NUM_OF_COLS)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      load_valid,
  output logic                                      load_ready,
  input  logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0]  load_vec,
  input  logic [0:1][COO_BW-1:0]                    load_coo,
  output logic                                      start,
  input  logic                                      enable_read,
  input  logic [ADDRESS_WIDTH-1:0]                  read_address,
  output logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0]  data_out,
  input  logic [COO_BW-1:0]                         coo_address,
  output logic [0:1][COO_BW-1:0]                    coo_out,
  input  logic                                      gcn_done,
  output logic                                      busy,
  output logic                                      addr_error
);

  localparam int VEC_TOTAL = WEIGHT_COLS + FEATURE_ROWS;
  localparam int VCW       = (VEC_TOTAL > 1) ? $clog2(VEC_TOTAL) : 1;

  typedef logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0] vec_t;
  typedef logic [0:1][COO_BW-1:0]                   coo_t;
  typedef enum logic [2:0] {S_IDLE, S_LOAD_VEC, S_LOAD_COO, S_START, S_RUN} state_t;

  state_t           state, state_nxt;
  logic [VCW-1:0]    vec_cnt;
  logic [COO_BW-1:0] coo_cnt;

  vec_t weight_mem [0:WEIGHT_COLS-1];
  vec_t feat_mem   [0:FEATURE_ROWS-1];
  coo_t coo_mem    [0:COO_NUM_OF_COLS-1];

  logic accept, vec_beat, coo_beat, last_vec, last_coo;
  logic rd_hit;
  vec_t rd_data;

  assign accept   = load_valid && load_ready;
  assign vec_beat = accept && (state == S_IDLE || state == S_LOAD_VEC);
  assign coo_beat = accept && (state == S_LOAD_COO);
  assign last_vec = (vec_cnt == VCW'(VEC_TOTAL - 1));
  assign last_coo = (coo_cnt == COO_BW'(COO_NUM_OF_COLS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (accept) state_nxt = last_vec ? S_LOAD_COO : S_LOAD_VEC;
      S_LOAD_VEC: if (accept && last_vec) state_nxt = S_LOAD_COO;
      S_LOAD_COO: if (accept && last_coo) state_nxt = S_START;
      S_START:    state_nxt = S_RUN;
      S_RUN:      if (gcn_done) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state == S_IDLE) || (state == S_LOAD_VEC) || (state == S_LOAD_COO);
    start      = (state == S_START);
    busy       = (state != S_IDLE);
  end

  // Counters wrap to 0 on their last beat, so every load begins at beat 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_cnt <= '0;
      coo_cnt <= '0;
    end else begin
      if (vec_beat) vec_cnt <= last_vec ? '0 : vec_cnt + 1'b1;
      if (coo_beat) coo_cnt <= last_coo ? '0 : coo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WEIGHT_COLS; i++)
      if (vec_beat && vec_cnt == VCW'(i)) weight_mem[i] <= load_vec;
    for (int i = 0; i < FEATURE_ROWS; i++)
      if (vec_beat && vec_cnt == VCW'(WEIGHT_COLS + i)) feat_mem[i] <= load_vec;
    for (int k = 0; k < COO_NUM_OF_COLS; k++)
      if (coo_beat && coo_cnt == COO_BW'(k)) coo_mem[k] <= load_coo;
  end

  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    for (int i = 0; i < WEIGHT_COLS; i++)
      if (read_address == ADDRESS_WIDTH'(i)) begin
        rd_hit  = 1'b1;
        rd_data = weight_mem[i];
      end
    for (int i = 0; i < FEATURE_ROWS; i++)
      if (read_address == ADDRESS_WIDTH'(FEATURE_BASE + i)) begin
        rd_hit  = 1'b1;
        rd_data = feat_mem[i];
      end
  end

  // Reads are honoured only in RUN; the error flag clears when a fresh load begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      addr_error <= 1'b0;
    end else begin
      if (state == S_RUN && enable_read) begin
        data_out <= rd_data;
        if (!rd_hit) addr_error <= 1'b1;
      end else if (state == S_IDLE && accept) begin
        addr_error <= 1'b0;
      end
    end
  end

  always_comb begin
    coo_out = '0;
    for (int k = 0; k < COO_NUM_OF_COLS; k++)
      if (coo_address == COO_BW'(k)) coo_out = coo_mem[k];
  end

endmodule

// File: tb/tb_gcn_input_buffer.sv
// Directed bench for gcn_input_buffer: load sequencing, start pulse, read/COO ports,
// address errors, host stalls and mid-load reset.
module tb_gcn_input_buffer;
  localparam int WR = 96;
  localparam int WW = 5;
  localparam int AW = 13;
  localparam int CB = 3;

  logic                   clk, reset, load_valid, load_ready, start, enable_read;
  logic                   gcn_done, busy, addr_error;
  logic [0:WR-1][WW-1:0]  load_vec, data_out, exp_vec;
  logic [0:1][CB-1:0]     load_coo, coo_out;
  logic [AW-1:0]          read_address;
  logic [CB-1:0]          coo_address;
  logic [0:1][CB-1:0]     exp_coo [0:5];
  int checks, errors;

  gcn_input_buffer dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_vec(load_vec), .load_coo(load_coo), .start(start),
    .enable_read(enable_read), .read_address(read_address), .data_out(data_out),
    .coo_address(coo_address), .coo_out(coo_out), .gcn_done(gcn_done),
    .busy(busy), .addr_error(addr_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [0:WR-1][WW-1:0] splat(input int v);
    logic [0:WR-1][WW-1:0] r;
    for (int e = 0; e < WR; e++) r[e] = WW'(v);
    return r;
  endfunction

  task automatic vec_beat(input int val);
    load_valid = 1'b1;
    load_vec   = splat(val);
    load_coo   = '1;
    @(posedge clk); #1;
  endtask

  // 15-beat load: vector beat b carries base+b, COO pairs are recorded in exp_coo.
  // A 3-cycle host stall is inserted before beat stall_at (none if negative).
  task automatic load_all(input int base, input int stall_at, input int coo_off);
    int early_starts;
    early_starts = 0;
    for (int b = 0; b < 15; b++) begin
      if (b == stall_at) begin
        load_valid = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          if (start) early_starts++;
        end
      end
      if (b < 9) vec_beat(base + b);
      else begin
        load_valid  = 1'b1;
        load_vec    = splat(31);
        load_coo[0] = CB'((b - 9 + coo_off) % 6);
        load_coo[1] = CB'((2 * (b - 9) + 1 + coo_off) % 6);
        exp_coo[b - 9] = load_coo;
        @(posedge clk); #1;
      end
      if (b < 14 && start) early_starts++;
      if (b == 0) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_first_beat got %b want 1", busy); end
      end
    end
    load_valid = 1'b0;
    checks++;
    if (early_starts !== 0) begin errors++; $display("FAIL start_early got %0d want 0", early_starts); end
    checks++;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL ready_after_load got %b want 0", load_ready); end
    checks++;
    if (start !== 1'b1) begin errors++; $display("FAIL start_pulse got %b want 1", start); end
    @(posedge clk); #1;
    checks++;
    if (start !== 1'b0) begin errors++; $display("FAIL start_width got %b want 0", start); end
    checks++;
    if (busy !== 1'b1 || load_ready !== 1'b0) begin
      errors++; $display("FAIL run_flags got busy=%b ready=%b want 1 0", busy, load_ready);
    end
  endtask

  task automatic do_read(input int addr);
    enable_read  = 1'b1;
    read_address = AW'(addr);
    @(posedge clk); #1;
    enable_read  = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (load_ready !== 1'b1 || start !== 1'b0 || busy !== 1'b0 || addr_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got ready=%b start=%b busy=%b err=%b want 1 0 0 0",
               load_ready, start, busy, addr_error);
    end
    checks++;
    if (data_out !== splat(0)) begin errors++; $display("FAIL reset_data got %0h want 0", data_out[0]); end
    // reads and done outside RUN are ignored
    gcn_done = 1'b1;
    do_read(3);
    gcn_done = 1'b0;
    checks++;
    if (addr_error !== 1'b0 || data_out !== splat(0) || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore got err=%b data=%0h busy=%b want 0 0 0", addr_error, data_out[0], busy);
    end
  endtask

  task automatic test_full_load;
    load_all(0, -1, 0);
  endtask

  task automatic test_read;
    do_read(2);
    checks++;
    if (data_out !== splat(2)) begin errors++; $display("FAIL read_w2 got %0d want 2", data_out[0]); end
    do_read(517);
    checks++;
    if (data_out !== splat(8)) begin errors++; $display("FAIL read_f5 got %0d want 8", data_out[WR-1]); end
    read_address = AW'(0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (data_out !== splat(8)) begin errors++; $display("FAIL read_hold got %0d want 8", data_out[0]); end
  endtask

  task automatic test_addr_error;
    checks++;
    if (addr_error !== 1'b0) begin errors++; $display("FAIL err_before got %b want 0", addr_error); end
    do_read(3);
    checks++;
    if (data_out !== splat(0) || addr_error !== 1'b1) begin
      errors++; $display("FAIL bad_addr got data=%0d err=%b want 0 1", data_out[0], addr_error);
    end
    do_read(518);
    do_read(2);
    checks++;
    if (data_out !== splat(2) || addr_error !== 1'b1) begin
      errors++; $display("FAIL err_sticky got data=%0d err=%b want 2 1", data_out[0], addr_error);
    end
  endtask

  task automatic test_coo;
    for (int k = 0; k < 6; k++) begin
      coo_address = CB'(k);
      #1;
      checks++;
      if (coo_out !== exp_coo[k]) begin
        errors++; $display("FAIL coo_%0d got %0h want %0h", k, coo_out, exp_coo[k]);
      end
    end
    coo_address = CB'(7);
    #1;
    checks++;
    if (coo_out !== '0) begin errors++; $display("FAIL coo_oob got %0h want 0", coo_out); end
  endtask

  task automatic test_done(input int hold_val);
    gcn_done = 1'b1;
    @(posedge clk); #1;
    gcn_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || load_ready !== 1'b1) begin
      errors++; $display("FAIL done got busy=%b ready=%b want 0 1", busy, load_ready);
    end
    do_read(0);
    checks++;
    if (data_out !== splat(hold_val)) begin
      errors++; $display("FAIL idle_hold got %0d want %0d", data_out[0], hold_val);
    end
  endtask

  task automatic test_stall;
    vec_beat(10);
    checks++;
    if (addr_error !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 1->0", addr_error); end
    // the beat above was vector beat 0; finish the remaining 14 with a stall before beat 5
    for (int b = 1; b < 5; b++) vec_beat(10 + b);
    load_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (start !== 1'b0 || load_ready !== 1'b1) begin
      errors++; $display("FAIL stall_state got start=%b ready=%b want 0 1", start, load_ready);
    end
    for (int b = 5; b < 9; b++) vec_beat(10 + b);
    for (int k = 0; k < 6; k++) begin
      load_valid  = 1'b1;
      load_vec    = splat(31);
      load_coo[0] = CB'((k + 3) % 6);
      load_coo[1] = CB'(5 - k);
      exp_coo[k]  = load_coo;
      @(posedge clk); #1;
      if (k < 5) begin
        checks++;
        if (start !== 1'b0) begin errors++; $display("FAIL stall_early_start got %b want 0 at coo %0d", start, k); end
      end
    end
    load_valid = 1'b0;
    checks++;
    if (start !== 1'b1) begin errors++; $display("FAIL stall_start got %b want 1", start); end
    @(posedge clk); #1;
    do_read(0);
    checks++;
    if (data_out !== splat(10)) begin errors++; $display("FAIL stall_w0 got %0d want 10", data_out[0]); end
    do_read(512);
    checks++;
    if (data_out !== splat(13)) begin errors++; $display("FAIL stall_f0 got %0d want 13", data_out[0]); end
    test_coo();
    test_done(13);
  endtask

  task automatic test_reset_midload;
    for (int b = 0; b < 5; b++) vec_beat(20 + b);
    load_valid = 1'b0;
    reset = 1'b1;
    #2;
    checks++;
    if (busy !== 1'b0 || load_ready !== 1'b1) begin
      errors++; $display("FAIL midload_reset got busy=%b ready=%b want 0 1", busy, load_ready);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    load_all(7, -1, 1);
    do_read(1);
    checks++;
    if (data_out !== splat(8)) begin errors++; $display("FAIL reload_w1 got %0d want 8", data_out[0]); end
    do_read(514);
    checks++;
    if (data_out !== splat(12)) begin errors++; $display("FAIL reload_f2 got %0d want 12", data_out[0]); end
    test_coo();
    test_done(12);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; load_valid = 1'b0; load_vec = '0; load_coo = '0;
    enable_read = 1'b0; read_address = '0; coo_address = '0; gcn_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_full_load();
    test_read();
    test_addr_error();
    test_coo();
    test_done(2);
    test_stall();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
